// File: rtl/debug_scan_ctrl_if.sv
// debug_scan_ctrl_if
//   Host-side command channel and captured-word stream of the debug scan
//   sequencer, bundled together.
//   Command channel : cmd_valid / cmd_ready handshake carrying cmd_base,
//                     cmd_count, plus the cmd_abort level.
//   Output stream   : dout_valid / dout_ready handshake carrying dout_data
//                     and the dout_last end-of-scan marker.
//   master = host / link side, slave = scan controller.
interface debug_scan_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_base;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;
  logic             dout_valid;
  logic             dout_ready;
  logic [31:0]      dout_data;
  logic             dout_last;

  modport master (
    output cmd_valid, cmd_base, cmd_count, cmd_abort, dout_ready,
    input  cmd_ready, dout_valid, dout_data, dout_last
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_count, cmd_abort, dout_ready,
    output cmd_ready, dout_valid, dout_data, dout_last
  );
endinterface

// File: rtl/debug_scan_ctrl.sv
// debug_scan_ctrl
//   Walks consecutive debug-bus addresses starting at a host-supplied base,
//   waits SETTLE cycles at each address for the debug unit's synchronous
//   reads, captures chk_data and streams it out with valid/ready.
// Parameters
//   SETTLE : cycles from an address change to data capture (1..15)
//   CNT_W  : width of the word-count field
// Ports
//   clk, rstn   : clock (rising edge), async active-low reset
//   bus         : command channel + output word stream (slave side)
//   chk_addr    : registered address to the debug unit
//   chk_data    : read data returned for chk_addr
//   busy        : controller is not idle
//   done        : one-cycle pulse at the end of every scan
//   aborted     : one-cycle pulse alongside done when cmd_abort ended the scan
module debug_scan_ctrl #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  debug_scan_ctrl_if.slave   bus,
  output logic [31:0]        chk_addr,
  input  logic [31:0]        chk_data,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_e;

  // Counter reload: the cycle spent reaching WAIT counts as the first of the
  // SETTLE cycles, so capture lands exactly SETTLE edges after the address
  // change.
  localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [3:0]       wait_q;
  logic [31:0]      dout_data_q;
  logic             dout_valid_q;
  logic             dout_last_q;
  logic             done_q;
  logic             aborted_q;

  logic cmd_hs;
  logic dout_hs;
  logic last_word;

  assign cmd_hs    = bus.cmd_valid & bus.cmd_ready;
  assign dout_hs   = dout_valid_q & bus.dout_ready;
  assign last_word = (remaining_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      wait_q       <= '0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Address is deliberately left alone here so a single probe can
          // be watched continuously between scans.
          if (cmd_hs) begin
            if (bus.cmd_count == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= bus.cmd_base;
              remaining_q <= bus.cmd_count;
              wait_q      <= WAIT_INIT;
              state_q     <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (bus.cmd_abort) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b1;
            aborted_q    <= 1'b1;
            state_q      <= S_IDLE;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            dout_data_q  <= chk_data;
            dout_valid_q <= 1'b1;
            dout_last_q  <= last_word;
            state_q      <= S_SEND;
          end
        end

        S_SEND: begin
          // Abort wins over a coincident handshake; that word is still
          // delivered, the scan just stops after it.
          if (bus.cmd_abort) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b1;
            aborted_q    <= 1'b1;
            state_q      <= S_IDLE;
          end else if (dout_hs) begin
            dout_valid_q <= 1'b0;
            if (last_word) begin
              dout_last_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              remaining_q <= remaining_q - CNT_W'(1);
              addr_q      <= addr_q + 32'd1;   // wraps naturally at 2^32
              wait_q      <= WAIT_INIT;
              state_q     <= S_WAIT;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;
  assign bus.dout_last  = dout_last_q;
  assign chk_addr       = addr_q;
  assign done           = done_q;
  assign aborted        = aborted_q;

endmodule

// File: tb/tb_debug_scan_ctrl.sv
module tb_debug_scan_ctrl;
  logic        clk;
  logic        rstn;
  logic [31:0] chk_addr;
  logic [31:0] chk_data;
  logic        busy, done, aborted;
  int          n_checks;
  int          n_errors;

  debug_scan_ctrl_if #(.CNT_W(16)) bus ();

  debug_scan_ctrl #(.SETTLE(2), .CNT_W(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .chk_addr (chk_addr),
    .chk_data (chk_data),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  // Debug unit model: data is a fixed function of the address.
  assign chk_data = chk_addr ^ 32'hA5A50000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [31:0] base, input logic [15:0] cnt);
    bus.cmd_valid = 1'b1;
    bus.cmd_base  = base;
    bus.cmd_count = cnt;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_count  = '0;
    bus.cmd_abort  = 1'b0;
    bus.dout_ready = 1'b1;

    // ---- reset
    tick(3);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_chk_addr", chk_addr, 32'd0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    rstn = 1'b1;
    tick(1);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_done", 32'(done), 32'd0);

    // ---- basic scan: base 5, count 3, ready held high
    send_cmd(32'h5, 16'd3);                                   // cycle 0
    chk("basic_addr0", chk_addr, 32'h5);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick(1);                                                  // cycle 1
    chk("basic_valid_c1", 32'(bus.dout_valid), 32'd0);
    tick(1);                                                  // cycle 2
    chk("basic_valid_w0", 32'(bus.dout_valid), 32'd1);
    chk("basic_data_w0", bus.dout_data, 32'hA5A50005);
    chk("basic_last_w0", 32'(bus.dout_last), 32'd0);
    tick(1);                                                  // cycle 3
    chk("basic_valid_c3", 32'(bus.dout_valid), 32'd0);
    chk("basic_addr1", chk_addr, 32'h6);
    tick(2);                                                  // cycle 5
    chk("basic_valid_w1", 32'(bus.dout_valid), 32'd1);
    chk("basic_data_w1", bus.dout_data, 32'hA5A50006);
    chk("basic_last_w1", 32'(bus.dout_last), 32'd0);
    tick(3);                                                  // cycle 8
    chk("basic_valid_w2", 32'(bus.dout_valid), 32'd1);
    chk("basic_data_w2", bus.dout_data, 32'hA5A50007);
    chk("basic_last_w2", 32'(bus.dout_last), 32'd1);
    chk("basic_done_c8", 32'(done), 32'd0);
    tick(1);                                                  // cycle 9
    chk("basic_done_c9", 32'(done), 32'd1);
    chk("basic_aborted_c9", 32'(aborted), 32'd0);
    chk("basic_valid_c9", 32'(bus.dout_valid), 32'd0);
    chk("basic_last_c9", 32'(bus.dout_last), 32'd0);
    chk("basic_busy_c9", 32'(busy), 32'd0);
    tick(1);
    chk("basic_done_c10", 32'(done), 32'd0);
    chk("basic_addr_hold", chk_addr, 32'h7);

    // ---- backpressure: base 0x100, count 2
    bus.dout_ready = 1'b0;
    send_cmd(32'h100, 16'd2);
    tick(2);                                                  // first valid
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", 32'(bus.dout_valid), 32'd1);
      chk("bp_data_hold", bus.dout_data, 32'hA5A50100);
      chk("bp_addr_hold", chk_addr, 32'h100);
      tick(1);
    end
    chk("bp_valid_after", 32'(bus.dout_valid), 32'd1);
    bus.dout_ready = 1'b1;
    tick(1);
    chk("bp_valid_drop", 32'(bus.dout_valid), 32'd0);
    chk("bp_addr1", chk_addr, 32'h101);
    tick(2);
    chk("bp_data_w1", bus.dout_data, 32'hA5A50101);
    chk("bp_last_w1", 32'(bus.dout_last), 32'd1);
    tick(1);
    chk("bp_done", 32'(done), 32'd1);

    // ---- zero count: no-op, address unchanged
    send_cmd(32'h5555, 16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid", 32'(bus.dout_valid), 32'd0);
    chk("zero_addr", chk_addr, 32'h101);
    chk("zero_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick(1);
    chk("zero_done_off", 32'(done), 32'd0);

    // ---- address wrap
    send_cmd(32'hFFFFFFFF, 16'd2);
    chk("wrap_addr0", chk_addr, 32'hFFFFFFFF);
    tick(2);
    chk("wrap_data0", bus.dout_data, 32'h5A5AFFFF);
    tick(1);
    chk("wrap_addr1", chk_addr, 32'h0);
    tick(2);
    chk("wrap_data1", bus.dout_data, 32'hA5A50000);
    chk("wrap_last1", 32'(bus.dout_last), 32'd1);
    tick(1);
    chk("wrap_done", 32'(done), 32'd1);

    // ---- abort on the 4th word, together with dout_ready
    send_cmd(32'h20, 16'd10);
    tick(11);                                                 // cycle 11: word 4
    chk("abort_valid_w3", 32'(bus.dout_valid), 32'd1);
    chk("abort_data_w3", bus.dout_data, 32'hA5A50023);
    bus.cmd_abort = 1'b1;
    tick(1);
    bus.cmd_abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_aborted", 32'(aborted), 32'd1);
    chk("abort_valid", 32'(bus.dout_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick(1);
    chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort_done_off", 32'(done), 32'd0);
    chk("abort_aborted_off", 32'(aborted), 32'd0);
    tick(3);
    chk("abort_no_5th", 32'(bus.dout_valid), 32'd0);

    // ---- asynchronous reset during WAIT
    send_cmd(32'h40, 16'd4);
    tick(1);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_addr", chk_addr, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mrst_valid", 32'(bus.dout_valid), 32'd0);
    chk("mrst_data", bus.dout_data, 32'd0);
    tick(2);
    chk("mrst_no_done", 32'(done), 32'd0);
    rstn = 1'b1;
    tick(1);
    chk("mrst_no_done_rel", 32'(done), 32'd0);
    send_cmd(32'h7, 16'd1);
    chk("mrst_new_addr", chk_addr, 32'h7);
    tick(2);
    chk("mrst_new_data", bus.dout_data, 32'hA5A50007);
    chk("mrst_new_last", 32'(bus.dout_last), 32'd1);
    tick(1);
    chk("mrst_new_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/debug_scan_ctrl.md
# debug_scan_ctrl

Sequencer that drives the debug bus address `chk_addr` of the CPU debug unit and streams the returned `chk_data` words out over a valid/ready interface. Given a base address and a word count, it walks consecutive debug addresses (pipeline probes, register file, instruction/data memory windows). At each address it waits a fixed settle time for synchronous memory reads, then captures one word. It sits between the debug unit and the host link (UART transmitter / host command parser).

## Interface
Parameters:
- `SETTLE`, 2: cycles between an address change and data capture; legal range 1..15.
- `CNT_W`, 16: width of the word-count field.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  host presents a scan command.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_base`  in  32  first debug address of the scan.
- `cmd_count`  in  CNT_W  number of words to read; 0 is a legal no-op.
- `cmd_abort`  in  1  terminate the current scan; ignored in IDLE.
- `chk_addr`  out  32  registered address to the debug unit.
- `chk_data`  in  32  debug unit read data, combinational from `chk_addr` plus memory latency.
- `dout_valid`  out  1  `dout_data` holds a captured word.
- `dout_ready`  in  1  sink accepts the word.
- `dout_data`  out  32  captured word.
- `dout_last`  out  1  high with `dout_valid` on the final word of a scan.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a scan ends (completed, zero-count or aborted).
- `aborted`  out  1  one-cycle pulse coincident with `done` when the end was caused by `cmd_abort`.

## Operation
- Reset values: state IDLE; `chk_addr`=0, `dout_data`=0, `dout_valid`=0, `dout_last`=0, `done`=0, `aborted`=0, remaining=0, wait counter=0. `cmd_ready`=1 and `busy`=0, both decoded from state.
- State IDLE:
  - Command handshake is `cmd_valid & cmd_ready`.
  - If `cmd_count`=0: stay in IDLE and pulse `done` on the next cycle. `chk_addr` is unchanged.
  - Otherwise: `chk_addr`<=`cmd_base`, remaining<=`cmd_count`, wait<=`SETTLE`-1, go to WAIT.
- State WAIT:
  - If wait≠0: wait decrements.
  - If wait=0: `dout_data`<=`chk_data`, `dout_valid`<=1, `dout_last`<=(remaining==1), go to SEND.
- State SEND:
  - `dout_data`, `dout_valid` and `dout_last` are held stable until `dout_valid & dout_ready`.
  - On handshake with remaining=1: `dout_valid`<=0, `dout_last`<=0, pulse `done`, go to IDLE.
  - On handshake with remaining>1: `dout_valid`<=0, remaining decrements, `chk_addr`<=`chk_addr`+1, wait<=`SETTLE`-1, go to WAIT.
- Address arithmetic: 32-bit increment, wrapping from 0xFFFFFFFF to 0x00000000. No range check.
- `chk_addr` holds its last value in IDLE so the host can monitor one probe continuously.
- Abort:
  - `cmd_abort` in WAIT or SEND: go to IDLE on the next edge, clear `dout_valid` and `dout_last`, pulse `done` and `aborted`.
  - Abort takes priority over a simultaneous `dout` handshake. That word counts as delivered, but no further word is produced.
- A command is never accepted on the same edge that a scan ends. `cmd_ready` rises the cycle after `done` is registered.
- Asynchronous reset mid-scan returns the block to reset values immediately. No `done` pulse is generated.

## Timing
- With command accepted at edge E0:
  - `chk_addr`=base is valid after E0.
  - Capture happens at edge E(`SETTLE`).
  - `dout_valid` rises after that edge.
- First-word latency is `SETTLE` cycles from acceptance. With `SETTLE`=2, `dout_valid` rises two cycles after acceptance.
- Per-word throughput with `dout_ready` held at 1: `SETTLE`+1 cycles (SEND 1 cycle + WAIT `SETTLE` cycles).
- N-word scan with `dout_ready`=1: `done` is high for one cycle, N·(`SETTLE`+1) cycles after acceptance.
- Zero-count command: `done` is high in the cycle following acceptance.

## Test plan
- Reset check: hold `rstn`=0 and then release. Required: `cmd_ready`=1, `busy`=0, `chk_addr`=0, and `dout_valid`/`done`/`aborted`=0.
- Basic scan (`SETTLE`=2): base=0x00000005, count=3, `chk_data` model returns addr^0xA5A50000, `dout_ready`=1. Required:
  - words 0xA5A50005, 0xA5A50006, 0xA5A50007;
  - `dout_last` set only on the third;
  - `done` pulses 9 cycles after acceptance.
- Backpressure: count=2, `dout_ready`=0 for 5 cycles after the first `dout_valid`. Required: `dout_data`/`dout_valid` stable for all 5 cycles, `chk_addr` unchanged, then normal completion.
- Zero count and wrap:
  - count=0: `done` pulses in the next cycle, no `dout_valid`.
  - base=0xFFFFFFFF, count=2: addresses 0xFFFFFFFF then 0x00000000.
- Abort: count=10, assert `cmd_abort` together with `dout_ready` on the 4th word. Required: `done`+`aborted` pulse in the next cycle, no 5th word, `cmd_ready`=1 the cycle after.
- Reset mid-scan: drop `rstn` during WAIT of a 4-word scan. Required: all outputs return to reset values asynchronously, no `done`, and a new command is accepted after release.
